// File: rtl/bounce_emulator.sv
// bounce_emulator
//
// Mechanical-switch emulator. A change on the clean target level is turned
// into a contact-bouncing waveform: pseudo-random glitches of bounded width
// for a fixed window, followed by a settle period at the final level. With
// bounce_en low the new level is passed straight through.
//
// Parameters:
//   BOUNCE_CYCLES  length of the bounce window in clk cycles (>= 1)
//   MIN_HOLD       minimum cycles between glitch toggles; also settle length (>= 1)
//   SEED           LFSR reset value (0 is replaced by 16'h0001)
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   level_in   clean target level, synchronous to clk
//   bounce_en  1 = emulate bounce, 0 = clean pass-through (sampled on the event cycle)
//   btn_out    emulated switch contact, registered
//   busy       high while bouncing or settling
//   done       one-cycle pulse once btn_out has settled at the target

module bounce_emulator #(
    parameter int unsigned BOUNCE_CYCLES = 64,
    parameter int unsigned MIN_HOLD      = 2,
    parameter logic [15:0] SEED          = 16'hACE1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic level_in,
    input  logic bounce_en,
    output logic btn_out,
    output logic busy,
    output logic done
);

    localparam int unsigned WinW  = $clog2(BOUNCE_CYCLES) + 1;
    localparam int unsigned HoldW = $clog2(MIN_HOLD) + 1;

    localparam logic [WinW-1:0]  WinLoad  = WinW'(BOUNCE_CYCLES - 1);
    localparam logic [WinW-1:0]  WinOne   = WinW'(1);
    localparam logic [HoldW-1:0] HoldLoad = HoldW'(MIN_HOLD - 1);
    localparam logic [HoldW-1:0] HoldOne  = HoldW'(1);

    // Galois form of x^16 + x^14 + x^13 + x^11 + 1; an all-zero seed would lock up.
    localparam logic [15:0] LfsrMask = 16'hB400;
    localparam logic [15:0] LfsrInit = (SEED == 16'h0000) ? 16'h0001 : SEED;

    typedef enum logic [1:0] {
        StIdle,
        StBounce,
        StSettle
    } state_e;

    state_e            state_q,    state_d;
    logic [15:0]       lfsr_q,     lfsr_d;
    logic              level_q,    level_d;
    logic              target_q,   target_d;
    logic              btn_q,      btn_d;
    logic              busy_q,     busy_d;
    logic              done_q,     done_d;
    logic [WinW-1:0]   win_cnt_q,  win_cnt_d;
    logic [HoldW-1:0]  hold_cnt_q, hold_cnt_d;
    logic [HoldW-1:0]  set_cnt_q,  set_cnt_d;

    // The LFSR free-runs in every state so the glitch pattern depends on when
    // an event arrives, yet stays fully repeatable from reset.
    always_comb begin
        lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LfsrMask : 16'h0000);
    end

    always_comb begin
        state_d    = state_q;
        level_d    = level_q;
        target_d   = target_q;
        btn_d      = btn_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        win_cnt_d  = win_cnt_q;
        hold_cnt_d = hold_cnt_q;
        set_cnt_d  = set_cnt_q;

        unique case (state_q)
            StIdle: begin
                if (level_in != level_q) begin
                    level_d  = level_in;
                    target_d = level_in;
                    // First contact is immediate in both modes.
                    btn_d    = level_in;
                    if (bounce_en) begin
                        win_cnt_d  = WinLoad;
                        hold_cnt_d = HoldLoad;
                        busy_d     = 1'b1;
                        state_d    = StBounce;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end

            StBounce: begin
                if (hold_cnt_q != '0) begin
                    hold_cnt_d = hold_cnt_q - HoldOne;
                end else if (lfsr_q[0]) begin
                    btn_d      = ~btn_q;
                    hold_cnt_d = HoldLoad;
                end

                // End of window overrides any toggle chosen above; this forced
                // write may cut the last glitch run short.
                if (win_cnt_q == '0) begin
                    btn_d     = target_q;
                    set_cnt_d = HoldLoad;
                    state_d   = StSettle;
                end else begin
                    win_cnt_d = win_cnt_q - WinOne;
                end
            end

            StSettle: begin
                btn_d = target_q;
                if (set_cnt_q == '0) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = StIdle;
                end else begin
                    set_cnt_d = set_cnt_q - HoldOne;
                end
            end

            default: begin
                busy_d  = 1'b0;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            lfsr_q     <= LfsrInit;
            level_q    <= 1'b0;
            target_q   <= 1'b0;
            btn_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            win_cnt_q  <= '0;
            hold_cnt_q <= '0;
            set_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            lfsr_q     <= lfsr_d;
            level_q    <= level_d;
            target_q   <= target_d;
            btn_q      <= btn_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            win_cnt_q  <= win_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            set_cnt_q  <= set_cnt_d;
        end
    end

    assign btn_out = btn_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule
